// File: rtl/rgb_fade_top_if.sv
// rtl/rgb_fade_top_if.sv - RGB LED drive bundle between the fader and the pins
interface rgb_fade_top_if;
  logic RGB_R;
  logic RGB_G;
  logic RGB_B;

  modport master (output RGB_R, output RGB_G, output RGB_B);
  modport slave  (input  RGB_R, input  RGB_G, input  RGB_B);
endinterface

// File: rtl/rgb_fade_top.sv
// rtl/rgb_fade_top.sv - six-phase HSV hue-wheel fader driving three PWM LED channels
// Define RGB_FADE_ACTIVE_HIGH_EN for active-high LED drive (default active-low).
module rgb_fade_top #(
  parameter int PWM_INTERVAL     = 1200,
  parameter int INC_DEC_INTERVAL = 10000,
  parameter int INC_DEC_MAX      = 200
) (
  input  logic            clk,
  input  logic            rst,
  rgb_fade_top_if.master  led
);

  localparam int INC_DEC_VAL = PWM_INTERVAL / INC_DEC_MAX;
  localparam int DUTY_W = $clog2(PWM_INTERVAL + 1);
  localparam int CNT_W  = (PWM_INTERVAL > 1)     ? $clog2(PWM_INTERVAL)     : 1;
  localparam int TMR_W  = (INC_DEC_INTERVAL > 1) ? $clog2(INC_DEC_INTERVAL) : 1;
  localparam int IDX_W  = (INC_DEC_MAX > 1)      ? $clog2(INC_DEC_MAX)      : 1;

  localparam logic [DUTY_W-1:0] FULL     = DUTY_W'(PWM_INTERVAL);
  localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(INC_DEC_VAL);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PWM_INTERVAL - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(INC_DEC_INTERVAL - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(INC_DEC_MAX - 1);

`ifdef RGB_FADE_ACTIVE_HIGH_EN
  localparam logic LED_ON = 1'b1;
`else
  localparam logic LED_ON = 1'b0;
`endif

  typedef enum logic [2:0] {P0, P1, P2, P3, P4, P5} phase_e;

  phase_e             phase_q, phase_d;
  logic [TMR_W-1:0]   step_tmr_q, step_tmr_d;
  logic [IDX_W-1:0]   step_idx_q, step_idx_d;
  logic [CNT_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [DUTY_W-1:0]  duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
  logic [DUTY_W-1:0]  cmp_r_q, cmp_r_d, cmp_g_q, cmp_g_d, cmp_b_q, cmp_b_d;
  logic               rgb_r_q, rgb_r_d, rgb_g_q, rgb_g_d, rgb_b_q, rgb_b_d;
  logic [DUTY_W-1:0]  cnt_ext;

  function automatic logic [DUTY_W-1:0] ramp_up(input logic [DUTY_W-1:0] d);
    return (d >= FULL - STEP) ? FULL : d + STEP;
  endfunction

  function automatic logic [DUTY_W-1:0] ramp_down(input logic [DUTY_W-1:0] d);
    return (d <= STEP) ? '0 : d - STEP;
  endfunction

  always_comb begin
    phase_d    = phase_q;
    step_tmr_d = step_tmr_q;
    step_idx_d = step_idx_q;
    duty_r_d   = duty_r_q;
    duty_g_d   = duty_g_q;
    duty_b_d   = duty_b_q;
    cmp_r_d    = cmp_r_q;
    cmp_g_d    = cmp_g_q;
    cmp_b_d    = cmp_b_q;
    cnt_ext    = DUTY_W'(pwm_cnt_q);

    pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + 1'b1;

    // The compare used at count 0 is the freshly latched duty, so a new
    // period starts cleanly with its own duty.
    if (pwm_cnt_q == '0) begin
      cmp_r_d = duty_r_q;
      cmp_g_d = duty_g_q;
      cmp_b_d = duty_b_q;
    end
    rgb_r_d = (cnt_ext < cmp_r_d) ? LED_ON : ~LED_ON;
    rgb_g_d = (cnt_ext < cmp_g_d) ? LED_ON : ~LED_ON;
    rgb_b_d = (cnt_ext < cmp_b_d) ? LED_ON : ~LED_ON;

    if (step_tmr_q == TMR_LAST) begin
      step_tmr_d = '0;
      case (phase_q)
        P0:      duty_g_d = ramp_up(duty_g_q);
        P1:      duty_r_d = ramp_down(duty_r_q);
        P2:      duty_b_d = ramp_up(duty_b_q);
        P3:      duty_g_d = ramp_down(duty_g_q);
        P4:      duty_r_d = ramp_up(duty_r_q);
        P5:      duty_b_d = ramp_down(duty_b_q);
        default: ;
      endcase
      if (step_idx_q == IDX_LAST) begin
        step_idx_d = '0;
        case (phase_q)
          P0:      phase_d = P1;
          P1:      phase_d = P2;
          P2:      phase_d = P3;
          P3:      phase_d = P4;
          P4:      phase_d = P5;
          default: phase_d = P0;
        endcase
      end else begin
        step_idx_d = step_idx_q + 1'b1;
      end
    end else begin
      step_tmr_d = step_tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= P0;
      step_tmr_q <= '0;
      step_idx_q <= '0;
      pwm_cnt_q  <= '0;
      duty_r_q   <= FULL;
      duty_g_q   <= '0;
      duty_b_q   <= '0;
      cmp_r_q    <= FULL;
      cmp_g_q    <= '0;
      cmp_b_q    <= '0;
      rgb_r_q    <= ~LED_ON;
      rgb_g_q    <= ~LED_ON;
      rgb_b_q    <= ~LED_ON;
    end else begin
      phase_q    <= phase_d;
      step_tmr_q <= step_tmr_d;
      step_idx_q <= step_idx_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_r_q   <= duty_r_d;
      duty_g_q   <= duty_g_d;
      duty_b_q   <= duty_b_d;
      cmp_r_q    <= cmp_r_d;
      cmp_g_q    <= cmp_g_d;
      cmp_b_q    <= cmp_b_d;
      rgb_r_q    <= rgb_r_d;
      rgb_g_q    <= rgb_g_d;
      rgb_b_q    <= rgb_b_d;
    end
  end

  assign led.RGB_R = rgb_r_q;
  assign led.RGB_G = rgb_g_q;
  assign led.RGB_B = rgb_b_q;

endmodule

// File: tb/tb_rgb_fade_top.sv
// tb/tb_rgb_fade_top.sv - directed bench for rgb_fade_top with a 12/4/4 configuration
module tb_rgb_fade_top;

`ifdef RGB_FADE_ACTIVE_HIGH_EN
  localparam logic ON = 1'b1;
`else
  localparam logic ON = 1'b0;
`endif
  localparam logic OFF = ~ON;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   n = 0;
  int   cnt_r = 0;
  int   cnt_g = 0;

  // expected duties (R,G,B) at the end of phases P0..P5
  int exp_r [6] = '{12, 0, 0, 0, 12, 12};
  int exp_g [6] = '{12, 12, 12, 0, 0, 0};
  int exp_b [6] = '{0, 0, 12, 12, 12, 0};
  int exp_cnt_r [3] = '{12, 12, 6};
  int exp_cnt_g [3] = '{0, 9, 12};

  rgb_fade_top_if led_if ();

  rgb_fade_top #(
    .PWM_INTERVAL     (12),
    .INC_DEC_INTERVAL (4),
    .INC_DEC_MAX      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .led (led_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    n++;
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("reset_r", 32'(led_if.RGB_R), 32'(OFF));
      chk("reset_g", 32'(led_if.RGB_G), 32'(OFF));
      chk("reset_b", 32'(led_if.RGB_B), 32'(OFF));
    end
    chk("reset_duty_r", 32'(dut.duty_r_q), 12);
    chk("reset_duty_g", 32'(dut.duty_g_q), 0);
    chk("reset_phase", 32'(dut.phase_q), 0);
    rst = 1'b0;

    step();
    chk("first_r", 32'(led_if.RGB_R), 32'(ON));
    chk("first_g", 32'(led_if.RGB_G), 32'(OFF));
    chk("first_b", 32'(led_if.RGB_B), 32'(OFF));
    if (led_if.RGB_R == ON) cnt_r++;
    if (led_if.RGB_G == ON) cnt_g++;

    while (n < 112) begin
      step();
      if (n <= 36) begin
        if (led_if.RGB_R == ON) cnt_r++;
        if (led_if.RGB_G == ON) cnt_g++;
        if (n % 12 == 0) begin
          chk("period_r_on", cnt_r, exp_cnt_r[n/12-1]);
          chk("period_g_on", cnt_g, exp_cnt_g[n/12-1]);
          cnt_r = 0;
          cnt_g = 0;
        end
      end
      if (n <= 16 && n % 4 == 0)
        chk("p0_duty_g", 32'(dut.duty_g_q), 3 * (n / 4));
      if (n % 16 == 0) begin
        chk("phase_end_r", 32'(dut.duty_r_q), exp_r[(n/16-1)%6]);
        chk("phase_end_g", 32'(dut.duty_g_q), exp_g[(n/16-1)%6]);
        chk("phase_end_b", 32'(dut.duty_b_q), exp_b[(n/16-1)%6]);
        chk("phase_end_idx", 32'(dut.step_idx_q), 0);
      end
      if (n == 96) begin
        chk("wrap_phase", 32'(dut.phase_q), 0);
        chk("wrap_tmr", 32'(dut.step_tmr_q), 0);
        chk("wrap_pwm", 32'(dut.pwm_cnt_q), 0);
        chk("wrap_cmp_r", 32'(dut.cmp_r_q), 12);
      end
      if (n == 112) chk("p1_phase", 32'(dut.phase_q), 1);
    end

    while (n < 150) step();
    chk("pre_rst_phase", 32'(dut.phase_q), 3);
    rst = 1'b1;
    step();
    chk("midrst_r", 32'(led_if.RGB_R), 32'(OFF));
    chk("midrst_g", 32'(led_if.RGB_G), 32'(OFF));
    chk("midrst_b", 32'(led_if.RGB_B), 32'(OFF));
    chk("midrst_duty_r", 32'(dut.duty_r_q), 12);
    chk("midrst_duty_g", 32'(dut.duty_g_q), 0);
    chk("midrst_duty_b", 32'(dut.duty_b_q), 0);
    chk("midrst_phase", 32'(dut.phase_q), 0);
    rst = 1'b0;
    step();
    chk("rerel_r", 32'(led_if.RGB_R), 32'(ON));
    chk("rerel_g", 32'(led_if.RGB_G), 32'(OFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
